// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scan-code decoder for a 13-key piano row with Z/X octave control.
// Define KEY_REPEAT_FILTER_EN to suppress typematic repeats of held note keys.
module ps2_note_decoder #(
    parameter logic [2:0] OCTAVE_RESET = 3'd4,
    parameter logic [2:0] OCTAVE_MAX   = 3'd7
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  received_data,
    input  logic        received_data_en,
    output logic        note_valid,
    output logic        note_on,
    output logic [3:0]  note_index,
    output logic [2:0]  note_octave,
    output logic [12:0] held_mask,
    output logic [2:0]  octave
);

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_OCT_DN = 8'h1A;
    localparam logic [7:0] CODE_OCT_UP = 8'h22;

    typedef enum logic [1:0] {
        IDLE,
        GOT_F0,
        GOT_E0,
        GOT_E0F0
    } state_t;

    state_t     state;
    logic       key_hit;
    logic [3:0] key_idx;

    always_comb begin
        key_hit = 1'b1;
        key_idx = 4'd0;
        case (received_data)
            8'h1C:   key_idx = 4'd0;
            8'h1D:   key_idx = 4'd1;
            8'h1B:   key_idx = 4'd2;
            8'h24:   key_idx = 4'd3;
            8'h23:   key_idx = 4'd4;
            8'h2B:   key_idx = 4'd5;
            8'h2C:   key_idx = 4'd6;
            8'h34:   key_idx = 4'd7;
            8'h35:   key_idx = 4'd8;
            8'h33:   key_idx = 4'd9;
            8'h3C:   key_idx = 4'd10;
            8'h3B:   key_idx = 4'd11;
            8'h42:   key_idx = 4'd12;
            default: key_hit = 1'b0;
        endcase
    end

    // NOTE: all state, including the event outputs, is written with <= so
    // every branch below sees the pre-edge values of held_mask and octave.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            held_mask   <= '0;
            octave      <= OCTAVE_RESET;
            note_valid  <= 1'b0;
            note_on     <= 1'b0;
            note_index  <= 4'd0;
            note_octave <= 3'd0;
        end else begin
            note_valid <= 1'b0;
            if (received_data_en) begin
                case (state)
                    IDLE: begin
                        if (received_data == CODE_BREAK) begin
                            state <= GOT_F0;
                        end else if (received_data == CODE_EXT) begin
                            state <= GOT_E0;
                        end else if (key_hit) begin
                            held_mask[key_idx] <= 1'b1;
`ifdef KEY_REPEAT_FILTER_EN
                            if (!held_mask[key_idx]) begin
                                note_valid  <= 1'b1;
                                note_on     <= 1'b1;
                                note_index  <= key_idx;
                                note_octave <= octave;
                            end
`else
                            note_valid  <= 1'b1;
                            note_on     <= 1'b1;
                            note_index  <= key_idx;
                            note_octave <= octave;
`endif
                        end else if (received_data == CODE_OCT_DN) begin
                            if (octave != 3'd0) octave <= octave - 3'd1;
                        end else if (received_data == CODE_OCT_UP) begin
                            if (octave < OCTAVE_MAX) octave <= octave + 3'd1;
                        end
                    end
                    GOT_F0: begin
                        if (received_data == CODE_BREAK) begin
                            state <= GOT_F0;
                        end else if (received_data == CODE_EXT) begin
                            state <= GOT_E0;
                        end else begin
                            state <= IDLE;
                            // A release of a key we never saw pressed is dropped.
                            if (key_hit && held_mask[key_idx]) begin
                                held_mask[key_idx] <= 1'b0;
                                note_valid  <= 1'b1;
                                note_on     <= 1'b0;
                                note_index  <= key_idx;
                                note_octave <= octave;
                            end
                        end
                    end
                    GOT_E0: begin
                        if (received_data == CODE_EXT)        state <= GOT_E0;
                        else if (received_data == CODE_BREAK) state <= GOT_E0F0;
                        else                                  state <= IDLE;
                    end
                    GOT_E0F0: begin
                        if (received_data == CODE_EXT)        state <= GOT_E0;
                        else if (received_data == CODE_BREAK) state <= GOT_E0F0;
                        else                                  state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
